// File: rtl/hazard_ctrl.sv
// Pipeline hazard/stall controller: drives the IF/ID and ID/EX register control pins.
// It handles load-use bubbles, memory freezes, branch flushes, HLT drain, and counts stall cycles.
module hazard_ctrl #(
  parameter logic [3:0] OPC_LW    = 4'h8,
  parameter logic [3:0] OPC_SW    = 4'h9,
  parameter logic [3:0] OPC_HLT   = 4'hF,
  parameter int         DRAIN_CYC = 3,
  parameter int         CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [15:0]      ifid_inst,
  input  logic [15:0]      idex_inst,
  input  logic             br_taken,
  input  logic             imem_busy,
  input  logic             dmem_busy,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_write,
  output logic             idex_stall_reset,
  output logic             idex_flush,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int DW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_MEM_WAIT,
    ST_DRAIN,
    ST_HALTED
  } state_t;

  state_t           state_reg, state_next;
  logic [DW-1:0]    drain_cnt_reg, drain_cnt_next;
  logic [CNT_W-1:0] stall_cnt_reg;

  logic [3:0] id_op;
  logic [3:0] ex_rd;
  logic       load_use;
  logic       stall_inc;
  logic       unused_ok;

  assign id_op     = ifid_inst[15:12];
  assign ex_rd     = idex_inst[11:8];
  assign unused_ok = ^idex_inst[7:0];

  // A store reads its data register from the rd field, so it also depends on the load.
  assign load_use = (idex_inst[15:12] == OPC_LW) && (ex_rd != 4'd0) &&
                    ((ex_rd == ifid_inst[7:4]) || (ex_rd == ifid_inst[3:0]) ||
                     ((id_op == OPC_SW) && (ex_rd == ifid_inst[11:8])));

  always_comb begin
    pc_write         = 1'b0;
    ifid_write       = 1'b0;
    ifid_flush       = 1'b0;
    idex_write       = 1'b0;
    idex_stall_reset = 1'b0;
    idex_flush       = 1'b0;
    halted           = 1'b0;
    state_next       = state_reg;
    drain_cnt_next   = drain_cnt_reg;

    case (state_reg)
      ST_RUN, ST_MEM_WAIT: begin
        if (dmem_busy) begin
          state_next = ST_MEM_WAIT;
        end else begin
          state_next = ST_RUN;
          if (load_use) begin
            idex_write       = 1'b1;
            idex_stall_reset = 1'b1;
          end else if (id_op == OPC_HLT) begin
            // HLT moves on to EX while fetch stops; the drain counts the remaining stages.
            ifid_write     = 1'b1;
            ifid_flush     = 1'b1;
            idex_write     = 1'b1;
            state_next     = ST_DRAIN;
            drain_cnt_next = DW'(DRAIN_CYC - 1);
          end else if (imem_busy) begin
            ifid_write = 1'b1;
            ifid_flush = 1'b1;
            idex_write = 1'b1;
          end else if (br_taken) begin
            pc_write   = 1'b1;
            ifid_write = 1'b1;
            ifid_flush = 1'b1;
            idex_write = 1'b1;
          end else begin
            pc_write   = 1'b1;
            ifid_write = 1'b1;
            idex_write = 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        if (!dmem_busy) begin
          ifid_write = 1'b1;
          ifid_flush = 1'b1;
          idex_write = 1'b1;
          idex_flush = 1'b1;
          if (drain_cnt_reg == '0) begin
            state_next = ST_HALTED;
          end else begin
            drain_cnt_next = drain_cnt_reg - 1'b1;
          end
        end
      end
      default: begin
        halted = 1'b1;
      end
    endcase

    if (rst) begin
      pc_write         = 1'b0;
      ifid_write       = 1'b0;
      ifid_flush       = 1'b0;
      idex_write       = 1'b0;
      idex_stall_reset = 1'b0;
      idex_flush       = 1'b0;
      halted           = 1'b0;
    end
  end

  assign stall_inc = ((state_reg == ST_RUN) || (state_reg == ST_MEM_WAIT)) && !pc_write;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= ST_RUN;
      drain_cnt_reg <= '0;
      stall_cnt_reg <= '0;
    end else begin
      state_reg     <= state_next;
      drain_cnt_reg <= drain_cnt_next;
      if (stall_inc && (stall_cnt_reg != {CNT_W{1'b1}})) begin
        stall_cnt_reg <= stall_cnt_reg + 1'b1;
      end
    end
  end

  assign stall_cnt = stall_cnt_reg;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed scenarios then random traffic against a rule-level model.
// Stimulus pushes expected outputs; a negedge monitor pops and compares.
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] ifid_inst, idex_inst;
  logic        br_taken, imem_busy, dmem_busy;
  logic        pc_write, ifid_write, ifid_flush, idex_write;
  logic        idex_stall_reset, idex_flush, halted;
  logic [15:0] stall_cnt;

  always #5 clk = ~clk;

  hazard_ctrl dut (
    .clk              (clk),
    .rst              (rst),
    .ifid_inst        (ifid_inst),
    .idex_inst        (idex_inst),
    .br_taken         (br_taken),
    .imem_busy        (imem_busy),
    .dmem_busy        (dmem_busy),
    .pc_write         (pc_write),
    .ifid_write       (ifid_write),
    .ifid_flush       (ifid_flush),
    .idex_write       (idex_write),
    .idex_stall_reset (idex_stall_reset),
    .idex_flush       (idex_flush),
    .halted           (halted),
    .stall_cnt        (stall_cnt)
  );

  typedef struct packed {
    logic [6:0]  o;   // {pc_write, ifid_write, ifid_flush, idex_write, idex_stall_reset, idex_flush, halted}
    logic [15:0] s;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   txn    = 0;

  // Reference model: halted flag, cycles of drain still to run, stall count.
  bit   m_halted     = 1'b0;
  int   m_drain_left = 0;
  int   m_stall      = 0;

  task automatic step(input logic r, input logic [15:0] fi, input logic [15:0] ei,
                      input logic b, input logic im, input logic dm);
    exp_t e;
    logic [3:0] rd;
    bit lu;
    @(posedge clk);
    #1;
    rst = r; ifid_inst = fi; idex_inst = ei; br_taken = b; imem_busy = im; dmem_busy = dm;
    e.o = 7'b0;
    if (r) begin
      m_halted = 1'b0; m_drain_left = 0; m_stall = 0;
      e.s = 16'd0;
    end else begin
      e.s = 16'(m_stall);
      if (m_halted) begin
        e.o = 7'b0000001;
      end else if (m_drain_left > 0) begin
        if (!dm) begin
          e.o = 7'b0111010;
          m_drain_left--;
          if (m_drain_left == 0) m_halted = 1'b1;
        end
      end else begin
        rd = ei[11:8];
        lu = (ei[15:12] == 4'h8) && (rd != 4'd0) &&
             (rd == fi[7:4] || rd == fi[3:0] || (fi[15:12] == 4'h9 && rd == fi[11:8]));
        if (dm)                    e.o = 7'b0000000;
        else if (lu)               e.o = 7'b0001100;
        else if (fi[15:12] == 4'hF) begin
          e.o = 7'b0111000;
          m_drain_left = 3;
        end
        else if (im)               e.o = 7'b0111000;
        else if (b)                e.o = 7'b1111000;
        else                       e.o = 7'b1101000;
        if (!e.o[6] && m_stall < 65535) m_stall++;
      end
    end
    q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      logic [6:0] got;
      e   = q.pop_front();
      got = {pc_write, ifid_write, ifid_flush, idex_write, idex_stall_reset, idex_flush, halted};
      checks++;
      txn++;
      if (got !== e.o || stall_cnt !== e.s) begin
        errors++;
        $display("FAIL txn %0d ctrl: got outs=%b cnt=%0d, expected outs=%b cnt=%0d",
                 txn, got, stall_cnt, e.o, e.s);
      end else begin
        $display("txn %0d ok outs=%b cnt=%0d", txn, got, stall_cnt);
      end
    end
  end

  initial begin
    logic [15:0] fi, ei;
    rst = 1'b1; ifid_inst = 16'h0; idex_inst = 16'h0;
    br_taken = 1'b0; imem_busy = 1'b0; dmem_busy = 1'b0;
    step(1, 16'h0000, 16'h0000, 0, 0, 0);
    step(1, 16'h0000, 16'h0000, 0, 0, 0);
    // load-use and its single bubble
    step(0, 16'h0312, 16'h8120, 0, 0, 0);
    step(0, 16'h0312, 16'h0000, 0, 0, 0);
    // LW to R0 never stalls; a store of the loaded register does
    step(0, 16'h0302, 16'h8020, 0, 0, 0);
    step(0, 16'h9140, 16'h8120, 0, 0, 0);
    // data memory freeze for four cycles, then resume
    repeat (4) step(0, 16'h0123, 16'h0456, 0, 0, 1);
    step(0, 16'h0123, 16'h0456, 0, 0, 0);
    // taken branch alone, then branch masked by a load-use stall
    step(0, 16'h0123, 16'h0456, 1, 0, 0);
    step(0, 16'h0123, 16'h0456, 0, 0, 0);
    step(0, 16'h0312, 16'h8120, 1, 0, 0);
    step(0, 16'h0123, 16'h0456, 0, 1, 0);
    // HLT, drain with one frozen cycle, then halted under arbitrary inputs
    step(0, 16'hF000, 16'h0000, 0, 0, 0);
    step(0, 16'h0000, 16'hF000, 0, 0, 0);
    step(0, 16'h0000, 16'h0000, 0, 0, 1);
    step(0, 16'h0000, 16'h0000, 0, 0, 0);
    step(0, 16'h0000, 16'h0000, 0, 0, 0);
    for (int i = 0; i < 6; i++)
      step(0, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    // reset in the middle of a memory wait, and in the middle of a drain
    step(1, 16'h0000, 16'h0000, 0, 0, 0);
    step(0, 16'h0000, 16'h0000, 0, 0, 1);
    step(0, 16'h0000, 16'h0000, 0, 0, 1);
    step(1, 16'h0000, 16'h0000, 0, 0, 1);
    step(0, 16'h0123, 16'h0456, 0, 0, 0);
    step(0, 16'hF000, 16'h0000, 0, 0, 0);
    step(0, 16'h0000, 16'hF000, 0, 0, 0);
    step(1, 16'h0000, 16'h0000, 0, 0, 0);
    step(0, 16'h0123, 16'h0456, 0, 0, 0);
    // random traffic biased towards register collisions and loads
    for (int i = 0; i < 400; i++) begin
      fi = 16'($urandom);
      ei = 16'($urandom);
      fi[11:0] = {2'b0, fi[11:10], 2'b0, fi[7:6], 2'b0, fi[3:2]};
      ei[11:8] = {2'b0, ei[9:8]};
      if ($urandom_range(0, 2) == 0) ei[15:12] = 4'h8;
      if ($urandom_range(0, 3) == 0) fi[15:12] = 4'h9;
      if (fi[15:12] == 4'hF && $urandom_range(0, 3) != 0) fi[15:12] = 4'h1;
      step(($urandom_range(0, 49) == 0), fi, ei,
           ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0), ($urandom_range(0, 4) == 0));
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d transactions left unchecked, required 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
